alu_cmd_issuer: RTL and testbench

//  Front-end driver for the 32-bit signed ALU controller. Buffers operation requests (a, b, sel, tag) in a

---
 rtl/alu_cmd_issuer_if.sv | 48 ++++
 rtl/alu_cmd_issuer.sv | 170 +++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_issuer_if.sv
// Bundles the request, ALU-side and response signals of alu_cmd_issuer.
// slave = the issuer itself, master = whatever drives requests and models the ALU.
interface alu_cmd_issuer_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_sel;
    logic [3:0]  req_tag;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_sel;
    logic [31:0] alu_out;
    logic [63:0] alu_out_m;
    logic        alu_cf;
    logic        alu_zf;
    logic        alu_of;
    logic        alu_nf;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [3:0]  rsp_tag;
    logic        rsp_err;
    logic        busy;

    modport slave (
        input  req_valid, req_a, req_b, req_sel, req_tag,
        output req_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_out, alu_out_m, alu_cf, alu_zf, alu_of, alu_nf,
        output rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_err,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req_valid, req_a, req_b, req_sel, req_tag,
        input  req_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_out, alu_out_m, alu_cf, alu_zf, alu_of, alu_nf,
        input  rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_err,
        output rsp_ready,
        input  busy
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Request FIFO + issue FSM in front of the 32-bit signed ALU; one op in flight at a time.
// Optional ILLEGAL_OP_TRAP_EN: opcodes 1100..1111 return rsp_err=1 with zero result/flags.
//
// state | meaning
// IDLE  | nothing in flight, waiting for a queued request
// EXEC  | operands on the ALU, counting down settle cycles
// RESP  | response held on rsp_* until rsp_ready
module alu_cmd_issuer #(
    parameter int FIFO_DEPTH = 4,
    parameter int MUL_WAIT   = 1
) (
    input logic             clk,
    input logic             rst,
    alu_cmd_issuer_if.slave bus
);

    localparam int          AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C    = (AW+1)'(FIFO_DEPTH);
    localparam logic [3:0]  MUL_WAIT_C = 4'(MUL_WAIT);
    localparam logic [3:0]  SEL_MUL    = 4'b0110;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [71:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          fifo_full, fifo_empty, push, pop;
    logic [71:0]   head;
    logic [3:0]    head_sel;

    logic [1:0]    state_q, state_d;
    logic [3:0]    wait_q, wait_d;
    logic          issue, capture;

    logic [31:0]   alu_a_q, alu_b_q;
    logic [3:0]    alu_sel_q, tag_q;

    logic          rsp_valid_q, rsp_valid_d;
    logic [63:0]   rsp_result_q, cap_result;
    logic [3:0]    rsp_flags_q, cap_flags;
    logic [3:0]    rsp_tag_q;
    logic          rsp_err_q, cap_err;

    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_empty = (count_q == '0);
    assign push       = bus.req_valid && !fifo_full;
    assign pop        = issue;
    assign head       = mem_q[rd_ptr_q];
    assign head_sel   = head[7:4];

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.req_a, bus.req_b, bus.req_sel, bus.req_tag};
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // RESP hands straight over to EXEC when more work is queued, so there is no IDLE bubble.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        rsp_valid_d = rsp_valid_q;
        issue       = 1'b0;
        capture     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) issue = 1'b1;
            end
            ST_EXEC: begin
                if (wait_q == '0) begin
                    capture     = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) issue   = 1'b1;
                    else             state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (issue) begin
            state_d = ST_EXEC;
            wait_d  = (head_sel == SEL_MUL) ? MUL_WAIT_C : 4'd0;
        end
    end

    always_comb begin
        cap_result = (alu_sel_q == SEL_MUL) ? bus.alu_out_m
                                            : {{32{bus.alu_out[31]}}, bus.alu_out};
        cap_flags  = {bus.alu_cf, bus.alu_zf, bus.alu_of, bus.alu_nf};
        cap_err    = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
        if (alu_sel_q[3:2] == 2'b11) begin
            cap_result = '0;
            cap_flags  = '0;
            cap_err    = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wait_q       <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= 4'hF;
            tag_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_tag_q    <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            rsp_valid_q <= rsp_valid_d;
            if (issue) begin
                alu_a_q   <= head[71:40];
                alu_b_q   <= head[39:8];
                alu_sel_q <= head_sel;
                tag_q     <= head[3:0];
            end
            if (capture) begin
                rsp_result_q <= cap_result;
                rsp_flags_q  <= cap_flags;
                rsp_tag_q    <= tag_q;
                rsp_err_q    <= cap_err;
            end
        end
    end

    assign bus.req_ready  = !fifo_full;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_sel    = alu_sel_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;
    assign bus.rsp_tag    = rsp_tag_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural ALU stub on the ALU side.
module tb_alu_cmd_issuer;

    logic clk;
    logic rst;
    int   checks;
    int   fails;
    int   cyc;

`ifdef ILLEGAL_OP_TRAP_EN
    localparam logic EXP_ILL_ERR = 1'b1;
`else
    localparam logic EXP_ILL_ERR = 1'b0;
`endif

    alu_cmd_issuer_if bus ();

    alu_cmd_issuer #(.FIFO_DEPTH(4), .MUL_WAIT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU stub: cf = borrow on subtract, of = signed overflow, zf/nf from the result
    logic [31:0]        m_sum, m_diff;
    logic signed [63:0] m_prod;
    assign m_sum  = bus.alu_a + bus.alu_b;
    assign m_diff = bus.alu_a - bus.alu_b;
    assign m_prod = $signed(bus.alu_a) * $signed(bus.alu_b);

    always_comb begin
        bus.alu_out   = '0;
        bus.alu_out_m = '0;
        bus.alu_cf    = 1'b0;
        bus.alu_zf    = 1'b0;
        bus.alu_of    = 1'b0;
        bus.alu_nf    = 1'b0;
        case (bus.alu_sel)
            4'b0100: begin
                bus.alu_out = m_sum;
                bus.alu_of  = (bus.alu_a[31] == bus.alu_b[31]) && (m_sum[31] != bus.alu_a[31]);
            end
            4'b0101: begin
                bus.alu_out = m_diff;
                bus.alu_cf  = bus.alu_a < bus.alu_b;
                bus.alu_of  = (bus.alu_a[31] != bus.alu_b[31]) && (m_diff[31] != bus.alu_a[31]);
            end
            4'b0110: begin
                bus.alu_out_m = m_prod;
                bus.alu_out   = m_prod[31:0];
            end
            4'b1001: bus.alu_out = {31'b0, $signed(bus.alu_a) < $signed(bus.alu_b)};
            4'b1010: bus.alu_out = {31'b0, bus.alu_a == bus.alu_b};
            4'b1011: bus.alu_out = {31'b0, $signed(bus.alu_a) > $signed(bus.alu_b)};
            default: ;
        endcase
        if (bus.alu_sel inside {4'b0100, 4'b0101, 4'b1001, 4'b1010, 4'b1011}) begin
            bus.alu_zf = (bus.alu_out == 32'd0);
            bus.alu_nf = bus.alu_out[31];
        end else if (bus.alu_sel == 4'b0110) begin
            bus.alu_zf = (bus.alu_out_m == 64'd0);
            bus.alu_nf = bus.alu_out_m[63];
        end
    end

    // Presents one request at a negedge and returns at the negedge after it was accepted.
    task automatic push(input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] sel, input logic [3:0] tag);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_sel   = sel;
        bus.req_tag   = tag;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            checks++;
            fails++;
            $display("FAIL push_timeout: req_ready=%0b required 1", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // Advances one cycle, dropping req_valid once the pending request has been taken.
    task automatic step();
        logic acc;
        acc = bus.req_valid && bus.req_ready;
        @(negedge clk);
        if (acc) bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_a = '0; bus.req_b = '0; bus.req_sel = '0; bus.req_tag = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL rst_req_ready: got %0b want 1", bus.req_ready); end
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %0b want 0", bus.busy); end
        checks++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid: got %0b want 0", bus.rsp_valid); end
        checks++; if (bus.alu_sel !== 4'hF) begin fails++; $display("FAIL rst_alu_sel: got %h want f", bus.alu_sel); end
        checks++; if (bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0) begin fails++; $display("FAIL rst_alu_ab: got %h/%h want 0/0", bus.alu_a, bus.alu_b); end
        checks++; if (bus.rsp_result !== 64'd0 || bus.rsp_tag !== 4'd0) begin fails++; $display("FAIL rst_rsp_fields: got %h/%h want 0/0", bus.rsp_result, bus.rsp_tag); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add_latency();
        bus.rsp_ready = 1'b1;
        push(32'd5, -32'sd3, 4'b0100, 4'd1);
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL add_early_valid: got %0b want 0", bus.rsp_valid); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1) begin fails++; $display("FAIL add_valid_t2: got %0b want 1", bus.rsp_valid); end
        checks++; if (bus.rsp_result !== 64'd2) begin fails++; $display("FAIL add_result: got %h want %h", bus.rsp_result, 64'd2); end
        checks++; if (bus.rsp_flags !== 4'b0000) begin fails++; $display("FAIL add_flags: got %b want 0000", bus.rsp_flags); end
        checks++; if (bus.rsp_tag !== 4'd1 || bus.rsp_err !== 1'b0) begin fails++; $display("FAIL add_tag_err: got %h/%0b want 1/0", bus.rsp_tag, bus.rsp_err); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL add_drain: valid=%0b busy=%0b want 0/0", bus.rsp_valid, bus.busy); end
        checks++; if (bus.alu_sel !== 4'b0100 || bus.alu_a !== 32'd5) begin fails++; $display("FAIL add_alu_hold: got %b/%h want 0100/5", bus.alu_sel, bus.alu_a); end
    endtask

    task automatic test_mul_latency();
        bus.rsp_ready = 1'b1;
        push(-32'sd7, 32'd6, 4'b0110, 4'd2);
        repeat (2) @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL mul_early_valid: got %0b want 0", bus.rsp_valid); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1) begin fails++; $display("FAIL mul_valid_t3: got %0b want 1", bus.rsp_valid); end
        checks++; if (bus.rsp_result !== 64'hFFFF_FFFF_FFFF_FFD6) begin fails++; $display("FAIL mul_result: got %h want ffffffffffffffd6", bus.rsp_result); end
        checks++; if (bus.rsp_flags !== 4'b0001 || bus.rsp_tag !== 4'd2) begin fails++; $display("FAIL mul_flags_tag: got %b/%h want 0001/2", bus.rsp_flags, bus.rsp_tag); end
        @(negedge clk);
    endtask

    task automatic test_vectors();
        logic [31:0] va [6];
        logic [31:0] vb [6];
        logic [3:0]  vs [6];
        logic [63:0] vr [6];
        logic [3:0]  vf [6];
        va[0] = 32'h8000_0000; vb[0] = 32'd1;  vs[0] = 4'b0101; vr[0] = 64'h0000_0000_7FFF_FFFF; vf[0] = 4'b0010;
        va[1] = 32'd1;         vb[1] = 32'd2;  vs[1] = 4'b0101; vr[1] = 64'hFFFF_FFFF_FFFF_FFFF; vf[1] = 4'b1001;
        va[2] = 32'd3;         vb[2] = -32'sd3; vs[2] = 4'b0100; vr[2] = 64'd0;                   vf[2] = 4'b0100;
        va[3] = -32'sd1;       vb[3] = 32'd1;  vs[3] = 4'b1001; vr[3] = 64'd1;                   vf[3] = 4'b0000;
        va[4] = 32'd7;         vb[4] = 32'd8;  vs[4] = 4'b1010; vr[4] = 64'd0;                   vf[4] = 4'b0100;
        va[5] = 32'd1;         vb[5] = 32'd2;  vs[5] = 4'b1101; vr[5] = 64'd0;                   vf[5] = 4'b0000;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            int n = 0;
            push(va[k], vb[k], vs[k], 4'(k + 8));
            while (!bus.rsp_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (bus.rsp_valid !== 1'b1) begin
                fails++; $display("FAIL vec%0d_timeout: rsp_valid=%0b want 1", k, bus.rsp_valid);
            end else if (bus.rsp_result !== vr[k] || bus.rsp_flags !== vf[k] || bus.rsp_tag !== 4'(k + 8)) begin
                fails++;
                $display("FAIL vec%0d: result=%h flags=%b tag=%h want %h/%b/%h",
                         k, bus.rsp_result, bus.rsp_flags, bus.rsp_tag, vr[k], vf[k], 4'(k + 8));
            end
            checks++;
            if (bus.rsp_err !== ((k == 5) ? EXP_ILL_ERR : 1'b0)) begin
                fails++; $display("FAIL vec%0d_err: got %0b want %0b", k, bus.rsp_err, (k == 5) ? EXP_ILL_ERR : 1'b0);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int last;
        bus.rsp_ready = 1'b0;
        for (int t = 0; t < 5; t++) push(32'(t), 32'd1, 4'b0100, 4'(t));
        bus.req_valid = 1'b1;
        bus.req_a = 32'd5; bus.req_b = 32'd1; bus.req_sel = 4'b0100; bus.req_tag = 4'd5;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 4'd0 || bus.rsp_result !== 64'd1) begin
                fails++;
                $display("FAIL bp_hold%0d: ready=%0b valid=%0b tag=%h result=%h want 0/1/0/1",
                         i, bus.req_ready, bus.rsp_valid, bus.rsp_tag, bus.rsp_result);
            end
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        last = cyc;
        for (int k = 0; k < 6; k++) begin
            int n = 0;
            while (!bus.rsp_valid && n < 20) begin
                step();
                n++;
            end
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 4'(k) || bus.rsp_result !== 64'(k + 1)) begin
                fails++;
                $display("FAIL bp_order%0d: valid=%0b tag=%h result=%h want 1/%0d/%0d",
                         k, bus.rsp_valid, bus.rsp_tag, bus.rsp_result, k, k + 1);
            end
            if (k > 0) begin
                checks++;
                if (cyc - last !== 2) begin
                    fails++; $display("FAIL bp_rate%0d: interval=%0d want 2", k, cyc - last);
                end
            end
            last = cyc;
            step();
        end
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL bp_idle: busy=%0b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid_exec();
        bit seen;
        bus.rsp_ready = 1'b0;
        push(32'd9, 32'd9, 4'b0100, 4'd9);
        for (int t = 1; t < 5; t++) push(32'(t), 32'd2, 4'b0100, 4'(t));
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b1 || bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL rm_exec: busy=%0b valid=%0b want 1/0", bus.busy, bus.rsp_valid); end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.alu_sel !== 4'hF || bus.req_ready !== 1'b1) begin
            fails++;
            $display("FAIL rm_async: valid=%0b busy=%0b sel=%h ready=%0b want 0/0/f/1",
                     bus.rsp_valid, bus.busy, bus.alu_sel, bus.req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin fails++; $display("FAIL rm_stale: activity after reset seen=%0b want 0", seen); end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        cyc    = 0;
        rst    = 1'b1;
        test_reset();
        test_add_latency();
        test_mul_latency();
        test_vectors();
        test_backpressure();
        test_reset_mid_exec();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
